sync_fifo_fwft: RTL and testbench

//   Single-clock, parametrised successor to the dual-clock FIFO. Depth is set by address width.

---
 rtl/sync_fifo_fwft_pkg.sv | 30 +++
 rtl/sync_fifo_fwft_if.sv | 30 +++
 rtl/sync_fifo_fwft_mem.sv | 42 ++++
 rtl/sync_fifo_fwft.sv | 152 +++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Sizing helpers for the FIFO family: depth and pointer width derived from the
// address width, plus a constant clog2 used by the parameter checks.
package sync_fifo_fwft_pkg;

  function automatic int clog2_f(input int value);
    int v;
    int result;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      v      = v >>> 1;
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic int depth_f(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

  // One extra pointer bit distinguishes full from empty when indices match.
  function automatic int ptr_width_f(input int addr_width);
    return addr_width + 32'sd1;
  endfunction

  function automatic bit in_range_f(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer handshake and status bundle of the single-clock FIFO.
interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] buf_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, buf_in, rd_en, clr_err,
    input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fill_count, overflow, underflow
  );

  modport slave (
    input  wr_en, buf_in, rd_en, clr_err,
    output buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fwft_mem.sv
// Simple dual-port RAM, one write port and one read port that is either
// registered (enable-gated, reset to zero) or asynchronous.
module sync_fifo_fwft_mem
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = depth_f(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, only advances when a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (re) begin
      rd_data_r <= mem_r[raddr];
    end
  end

  assign rdata = REG_OUT ? rd_data_r : mem_r[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with programmable almost flags, occupancy count, sticky
// error flags and selectable standard / first-word-fall-through read.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 56,
  parameter int AE_THRESH  = 8
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_fwft_if.slave fifo
);
  localparam int DEPTH = depth_f(ADDR_WIDTH);
  localparam int PW    = ptr_width_f(ADDR_WIDTH);

  if (ADDR_WIDTH < 2) begin : g_chk_aw
    $error("sync_fifo_fwft: ADDR_WIDTH must be at least 2");
  end
  if (!in_range_f(AF_THRESH, 1, DEPTH)) begin : g_chk_af
    $error("sync_fifo_fwft: AF_THRESH must lie in 1..DEPTH");
  end
  if (!in_range_f(AE_THRESH, 0, DEPTH - 1)) begin : g_chk_ae
    $error("sync_fifo_fwft: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (clog2_f(DEPTH + 1) != PW) begin : g_chk_pw
    $error("sync_fifo_fwft: pointer width cannot hold a count of DEPTH");
  end

  localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         count_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  ae_r;
  logic                  af_r;
  logic                  ovf_r;
  logic                  unf_r;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [PW-1:0]         wr_ptr_nxt_s;
  logic [PW-1:0]         rd_ptr_nxt_s;
  logic [PW-1:0]         count_nxt_s;
  logic                  empty_nxt_s;
  logic                  full_nxt_s;
  logic                  ovf_nxt_s;
  logic                  unf_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Accept/gating and next-state for pointers, status flags and error flags.
  // Flags are registered from the next pointers, so they equal functions of
  // the registered pointers one cycle later.
  always_comb begin
    wr_acc_s     = fifo.wr_en & ~full_r;
    rd_acc_s     = fifo.rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    ovf_nxt_s    = ovf_r;
    unf_nxt_s    = unf_r;

    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]) &&
                  (wr_ptr_nxt_s[PW-2:0] == rd_ptr_nxt_s[PW-2:0]);

    // A new violation outranks a simultaneous clear.
    if (fifo.wr_en & full_r) begin
      ovf_nxt_s = 1'b1;
    end else if (fifo.clr_err) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    if (fifo.rd_en & empty_r) begin
      unf_nxt_s = 1'b1;
    end else if (fifo.clr_err) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ae_r     <= 1'b1;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      empty_r  <= empty_nxt_s;
      full_r   <= full_nxt_s;
      ae_r     <= (count_nxt_s <= AE_LVL);
      af_r     <= (count_nxt_s >= AF_LVL);
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
    end
  end

  sync_fifo_fwft_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_OUT    (FWFT == 0)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[ADDR_WIDTH-1:0]),
    .wdata (fifo.buf_in),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r[ADDR_WIDTH-1:0]),
    .rdata (rdata_s)
  );

  assign fifo.buf_out      = rdata_s;
  assign fifo.buf_empty    = empty_r;
  assign fifo.buf_full     = full_r;
  assign fifo.almost_empty = ae_r;
  assign fifo.almost_full  = af_r;
  assign fifo.fill_count   = count_r;
  assign fifo.overflow     = ovf_r;
  assign fifo.underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench: a default standard-read FIFO against a queue model and
// hand-derived vectors, plus a small FWFT instance for fall-through timing.
module tb_sync_fifo_fwft;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sync_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) if_a ();
  sync_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_b ();

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(0), .AF_THRESH(56), .AE_THRESH(8)
  ) dut_a (.clk(clk), .rst(rst), .fifo(if_a));

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)
  ) dut_b (.clk(clk), .rst(rst), .fifo(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for dut_a: a plain queue of stored words.
  logic [7:0] mq[$];
  logic [7:0] m_out;
  bit         m_ovf;
  bit         m_unf;

  typedef struct packed {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [6:0] cnt;
    logic       emp;
    logic [7:0] out;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_out = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(bit wr, logic [7:0] din, bit rd, bit clr);
    bit was_full;
    bit was_empty;
    was_full  = (mq.size() == 64);
    was_empty = (mq.size() == 0);
    if (rd && !was_empty) m_out = mq.pop_front();
    if (wr && !was_full) mq.push_back(din);
    if (wr && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rd && was_empty) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
  endfunction

  task automatic check_all_a(input string tag);
    check({tag, ".count"}, 32'(if_a.fill_count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(if_a.buf_empty), 32'(mq.size() == 0));
    check({tag, ".full"}, 32'(if_a.buf_full), 32'(mq.size() == 64));
    check({tag, ".ae"}, 32'(if_a.almost_empty), 32'(mq.size() <= 8));
    check({tag, ".af"}, 32'(if_a.almost_full), 32'(mq.size() >= 56));
    check({tag, ".ovf"}, 32'(if_a.overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(if_a.underflow), 32'(m_unf));
    check({tag, ".data"}, 32'(if_a.buf_out), 32'(m_out));
  endtask

  // One clock on dut_a: drive, take the edge, sample 1 time unit later.
  task automatic cycle_a(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
    if_a.wr_en   = wr;
    if_a.buf_in  = din;
    if_a.rd_en   = rd;
    if_a.clr_err = clr;
    @(posedge clk);
    #1;
    model_step(wr, din, rd, clr);
    if_a.wr_en   = 1'b0;
    if_a.rd_en   = 1'b0;
    if_a.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    if_a.wr_en = 1'b0; if_a.rd_en = 1'b0; if_a.clr_err = 1'b0; if_a.buf_in = 8'h00;
    if_b.wr_en = 1'b0; if_b.rd_en = 1'b0; if_b.clr_err = 1'b0; if_b.buf_in = 8'h00;
    model_reset();

    //               wr    din    rd    clr   cnt   emp   out    ovf   unf
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 7'd0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 7'd1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 7'd1, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h33, 1'b1, 1'b0, 7'd1, 1'b0, 8'h22, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 7'd0, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 7'd0, 1'b1, 8'h33, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 7'd0, 1'b1, 8'h33, 1'b0, 1'b0};

    // Reset values on both instances.
    @(posedge clk);
    #1;
    check_all_a("reset");
    check("reset.b_empty", 32'(if_b.buf_empty), 32'd1);
    check("reset.b_ae", 32'(if_b.almost_empty), 32'd1);
    check("reset.b_count", 32'(if_b.fill_count), 32'd0);
    rst = 1'b0;

    // Hand-derived vectors: underflow, clear races, simultaneous read/write.
    for (int i = 0; i < 10; i++) begin
      cycle_a(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
      check($sformatf("vec%0d.count", i), 32'(if_a.fill_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d.empty", i), 32'(if_a.buf_empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d.data", i), 32'(if_a.buf_out), 32'(vecs[i].out));
      check($sformatf("vec%0d.ovf", i), 32'(if_a.overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d.unf", i), 32'(if_a.underflow), 32'(vecs[i].unf));
    end

    // Fill 0x01..0x40 then drain in order.
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      cycle_a(1'b1, 8'(i), 1'b0, 1'b0);
      check_all_a("fill");
      if (i == 55) check("af_at_55", 32'(if_a.almost_full), 32'd0);
      if (i == 56) check("af_at_56", 32'(if_a.almost_full), 32'd1);
      if (i == 63) check("full_at_63", 32'(if_a.buf_full), 32'd0);
    end
    check("full_at_64", 32'(if_a.buf_full), 32'd1);
    check("count_at_64", 32'(if_a.fill_count), 32'd64);
    for (int i = 1; i <= 64; i++) begin
      cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_data", 32'(if_a.buf_out), 32'(i));
      check_all_a("drain");
    end
    check("empty_after_drain", 32'(if_a.buf_empty), 32'd1);

    // Overflow / underflow / clear.
    do_reset();
    for (int i = 0; i < 64; i++) cycle_a(1'b1, 8'(8'hA0 ^ 8'(i)), 1'b0, 1'b0);
    cycle_a(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", 32'(if_a.overflow), 32'd1);
    check("ovf_count", 32'(if_a.fill_count), 32'd64);
    cycle_a(1'b1, 8'hEE, 1'b0, 1'b1);
    check("ovf_clr_race", 32'(if_a.overflow), 32'd1);
    for (int i = 0; i < 64; i++) begin
      cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
      check_all_a("ovf_drain");
    end
    cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", 32'(if_a.underflow), 32'd1);
    cycle_a(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(if_a.overflow), 32'd0);
    check("clr_unf", 32'(if_a.underflow), 32'd0);

    // Steady-state streaming at fill_count 10.
    do_reset();
    for (int i = 0; i < 10; i++) cycle_a(1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle_a(1'b1, 8'(8'h80 + 8'(i)), 1'b1, 1'b0);
      check("stream_count", 32'(if_a.fill_count), 32'd10);
      check_all_a("stream");
    end
    for (int i = 0; i < 10; i++) begin
      cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
      check_all_a("stream_drain");
    end

    // Random traffic in alternating write-heavy / read-heavy phases.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int  wp;
      bit  w;
      bit  r;
      bit  c;
      wp = (((i / 150) % 2) == 0) ? 80 : 30;
      w  = ($urandom_range(99) < 32'(wp));
      r  = ($urandom_range(99) < 32'(110 - wp));
      c  = ($urandom_range(99) < 5);
      cycle_a(w, 8'($urandom), r, c);
      check_all_a("rand");
    end

    // FWFT instance: head word visible right after the write edge.
    do_reset();
    if_b.wr_en  = 1'b1;
    if_b.buf_in = 8'hAA;
    @(posedge clk);
    #1;
    if_b.wr_en = 1'b0;
    check("fwft.empty", 32'(if_b.buf_empty), 32'd0);
    check("fwft.data", 32'(if_b.buf_out), 32'hAA);
    check("fwft.ae", 32'(if_b.almost_empty), 32'd1);
    check("fwft.count", 32'(if_b.fill_count), 32'd1);
    if_b.rd_en = 1'b1;
    @(posedge clk);
    #1;
    if_b.rd_en = 1'b0;
    check("fwft.empty_after_pop", 32'(if_b.buf_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if_b.wr_en  = 1'b1;
      if_b.buf_in = 8'(8'h3C + 8'(i));
      @(posedge clk);
      #1;
    end
    if_b.wr_en = 1'b0;
    check("fwft.ae_at_3", 32'(if_b.almost_empty), 32'd0);
    if_b.rd_en = 1'b1;
    @(posedge clk);
    #1;
    if_b.rd_en = 1'b0;
    check("fwft.next_head", 32'(if_b.buf_out), 32'h3D);
    check("fwft.ae_at_2", 32'(if_b.almost_empty), 32'd1);

    // Asynchronous reset mid-stream at fill_count 30.
    do_reset();
    for (int i = 0; i < 31; i++) cycle_a(1'b1, 8'(8'hC0 + 8'(i)), 1'b0, 1'b0);
    cycle_a(1'b1, 8'h01, 1'b1, 1'b0);
    check("pre_rst_count", 32'(if_a.fill_count), 32'd31);
    cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_count30", 32'(if_a.fill_count), 32'd30);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all_a("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle_a(1'b1, 8'h5A, 1'b0, 1'b0);
    check("post_rst_count", 32'(if_a.fill_count), 32'd1);
    cycle_a(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_data", 32'(if_a.buf_out), 32'h5A);
    check("post_rst_empty", 32'(if_a.buf_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
